// File: rtl/cdb_arbiter_if.sv
// Common data bus arbitration signals between the functional units and the arbiter.
// The master side drives requests and squashes; the slave side (the arbiter) drives the grant outputs.
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 7,
    parameter int CDB_WIDTH = 2,
    parameter int IDX_W     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         squash_mask;
    logic [NUM_REQ-1:0]         ack;
    logic [CDB_WIDTH-1:0]       slot_valid;
    logic [CDB_WIDTH*IDX_W-1:0] slot_src;
    logic                       cdb_full;
    logic [NUM_REQ-1:0]         starved;

    modport master (
        output req, squash_mask,
        input  ack, slot_valid, slot_src, cdb_full, starved
    );

    modport slave (
        input  req, squash_mask,
        output ack, slot_valid, slot_src, cdb_full, starved
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: starvation-promoted requesters first, then round-robin from rr_ptr,
// at most CDB_WIDTH grants and at most one branch-capable unit per cycle.
module cdb_arbiter #(
    parameter int                 NUM_REQ      = 7,
    parameter int                 CDB_WIDTH    = 2,
    parameter logic [NUM_REQ-1:0] BRANCH_MASK  = 7'b0000110,
    parameter int                 STARVE_LIMIT = 4,
    parameter int                 IDX_W        = $clog2(NUM_REQ)
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam logic [3:0]         LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [IDX_W:0]     LAST     = (IDX_W+1)'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] IDX0     = NUM_REQ'(1);

    logic [IDX_W-1:0]   rr_ptr;
    logic [3:0]         wait_cnt [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] starved_vec;
    logic [NUM_REQ-1:0] grant;
    logic [CDB_WIDTH-1:0] slot_used;
    logic [IDX_W-1:0]   slot_idx [CDB_WIDTH];
    logic               rr_hit;
    logic [IDX_W-1:0]   rr_last;
    logic               branch_taken;
    int                 n_grant;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   idx;

    // Reset gates eligibility, which forces every grant output low while reset is held.
    assign eligible = bus.req & ~bus.squash_mask & ~IDX0 & {NUM_REQ{reset}};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starved_vec[i] = (wait_cnt[i] == LIMIT);
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant        = '0;
        slot_used    = '0;
        rr_hit       = 1'b0;
        rr_last      = '0;
        branch_taken = 1'b0;
        n_grant      = 0;
        sum          = '0;
        idx          = '0;
        for (int s = 0; s < CDB_WIDTH; s++) begin
            slot_idx[s] = '0;
        end

        for (int i = 1; i < NUM_REQ; i++) begin
            if (eligible[i] && starved_vec[i] && n_grant < CDB_WIDTH &&
                !(BRANCH_MASK[i] && branch_taken)) begin
                grant[i]     = 1'b1;
                branch_taken = branch_taken | BRANCH_MASK[i];
                for (int s = 0; s < CDB_WIDTH; s++) begin
                    if (s == n_grant) begin
                        slot_used[s] = 1'b1;
                        slot_idx[s]  = IDX_W'(i);
                    end
                end
                n_grant = n_grant + 1;
            end
        end

        // Walk 1..NUM_REQ-1 starting at rr_ptr, wrapping past the last index back to 1.
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum > LAST) begin
                sum = sum - LAST;
            end
            idx = sum[IDX_W-1:0];
            if (eligible[idx] && !grant[idx] && n_grant < CDB_WIDTH &&
                !(BRANCH_MASK[idx] && branch_taken)) begin
                grant[idx]   = 1'b1;
                branch_taken = branch_taken | BRANCH_MASK[idx];
                rr_hit       = 1'b1;
                rr_last      = idx;
                for (int s = 0; s < CDB_WIDTH; s++) begin
                    if (s == n_grant) begin
                        slot_used[s] = 1'b1;
                        slot_idx[s]  = idx;
                    end
                end
                n_grant = n_grant + 1;
            end
        end
    end

    always_comb begin
        bus.ack        = grant;
        bus.slot_valid = slot_used;
        bus.cdb_full   = ($countones(eligible) > CDB_WIDTH);
        bus.starved    = starved_vec;
        bus.slot_src   = '0;
        for (int s = 0; s < CDB_WIDTH; s++) begin
            bus.slot_src[s*IDX_W +: IDX_W] = slot_idx[s];
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr <= IDX_W'(1);
            // NOTE: the wait counters are priority state, so every entry is cleared on reset.
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (rr_hit) begin
                rr_ptr <= (rr_last == LAST_IDX) ? IDX_W'(1) : rr_last + IDX_W'(1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] || !bus.req[i] || bus.squash_mask[i]) begin
                    wait_cnt[i] <= '0;
                end else if (eligible[i] && wait_cnt[i] != LIMIT) begin
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end
            end
        end
    end
endmodule
